// File: rtl/gpio_debounce_pkg.sv
// Shared defaults and counter types for the GPIO input debounce stage.
package gpio_debounce_pkg;

  // Default width of each pin's stability counter and of the threshold.
  localparam int DefaultCntWidth = 8;
  // Default width of the shared tick prescaler and of its reload value.
  localparam int DefaultPreWidth = 16;

  typedef logic [DefaultCntWidth-1:0] cnt_t;
  typedef logic [DefaultPreWidth-1:0] pre_t;

endpackage

// File: rtl/gpio_reg_pkg.sv
// GPIO register package slice: pin count shared by the GPIO peripheral
// and its input conditioning stage.
package gpio_reg_pkg;

  localparam int GPIOCount = 8;

endpackage

// File: rtl/gpio_debounce_cell.sv
// One pin of the GPIO input stage: pad synchronizer, tick-based stability
// counter, filtered output register and registered rise/fall pulses.
module gpio_debounce_cell
  import gpio_debounce_pkg::*;
#(
  parameter int CntWidth   = DefaultCntWidth,
  parameter int SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pad_i,
  input  logic                filt_en_i,
  input  logic                tick_i,
  input  logic [CntWidth-1:0] threshold_i,
  output logic                gpio_o,
  output logic                rise_o,
  output logic                fall_o
);

  localparam logic [CntWidth:0] CntOne = (CntWidth + 1)'(1);

  logic [SyncStages-1:0] sync_q;
  logic                  s;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [CntWidth:0]     cnt_inc;
  logic [CntWidth:0]     eff_thr;
  logic                  gpio_q, gpio_d;
  logic                  rise_q, fall_q;

  // Pad synchronizer: the pad enters at bit 0, the stable copy leaves the MSB.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: clocked state uses <= so every flop samples pre-edge values.
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SyncStages-2:0], pad_i};
  end

  assign s = sync_q[SyncStages-1];

  // A zero threshold behaves as one; one extra bit keeps cnt+1 from wrapping.
  assign eff_thr = (threshold_i == '0) ? CntOne : {1'b0, threshold_i};
  assign cnt_inc = {1'b0, cnt_q} + CntOne;

  // Filter decision: accept s once it has disagreed with gpio for eff_thr ticks.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    gpio_d = gpio_q;
    cnt_d  = cnt_q;
    if (!filt_en_i) begin
      gpio_d = s;
      cnt_d  = '0;
    end else if (s == gpio_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_inc >= eff_thr) begin
        gpio_d = s;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_inc[CntWidth-1:0];
      end
    end
  end

  // Output, counter and edge pulses update together so a pulse coincides with the new level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gpio_q <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      gpio_q <= gpio_d;
      cnt_q  <= cnt_d;
      rise_q <= gpio_d & ~gpio_q;
      fall_q <= ~gpio_d & gpio_q;
    end
  end

  assign gpio_o = gpio_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/gpio_in_debounce.sv
// GPIO input conditioning: a shared tick prescaler feeding one debounce
// cell per pin. Pins are independent apart from the common tick.
module gpio_in_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int NrGPIOs    = gpio_reg_pkg::GPIOCount,
  parameter int CntWidth   = DefaultCntWidth,
  parameter int PreWidth   = DefaultPreWidth,
  parameter int SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NrGPIOs-1:0]  pad_i,
  input  logic [NrGPIOs-1:0]  filt_en_i,
  input  logic [CntWidth-1:0] threshold_i,
  input  logic [PreWidth-1:0] prescale_i,
  output logic [NrGPIOs-1:0]  gpio_o,
  output logic [NrGPIOs-1:0]  rise_o,
  output logic [NrGPIOs-1:0]  fall_o
);

  localparam logic [PreWidth-1:0] PreOne = PreWidth'(1);

  logic [PreWidth-1:0] pre_q;
  logic                tick;

  // >= lets a prescale lowered below the running count take effect at once.
  assign tick = (pre_q >= prescale_i);

  // Free-running prescaler, wrapping to zero on the tick cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + PreOne;
  end

  for (genvar i = 0; i < NrGPIOs; i++) begin : g_pin
    gpio_debounce_cell #(
      .CntWidth   (CntWidth),
      .SyncStages (SyncStages)
    ) u_cell (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .pad_i       (pad_i[i]),
      .filt_en_i   (filt_en_i[i]),
      .tick_i      (tick),
      .threshold_i (threshold_i),
      .gpio_o      (gpio_o[i]),
      .rise_o      (rise_o[i]),
      .fall_o      (fall_o[i])
    );
  end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Self-checking bench for gpio_in_debounce: a vector table for bypass mode,
// directed multi-cycle sequences for the filter corners, and a randomized
// run compared against a tick-counting reference model.
module tb_gpio_in_debounce;
  import gpio_debounce_pkg::*;

  localparam int N    = gpio_reg_pkg::GPIOCount;
  localparam int Sync = 2;

  typedef logic [N-1:0] pins_t;

  typedef struct {
    pins_t pad;
    pins_t en;
    pins_t gpio;
    pins_t rise;
    pins_t fall;
  } row_t;

  logic  clk;
  logic  rst_ni;
  pins_t pad_i, filt_en_i;
  cnt_t  threshold_i;
  pre_t  prescale_i;
  pins_t gpio_o, rise_o, fall_o;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_in_debounce #(
    .NrGPIOs    (N),
    .CntWidth   (DefaultCntWidth),
    .PreWidth   (DefaultPreWidth),
    .SyncStages (Sync)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .pad_i       (pad_i),
    .filt_en_i   (filt_en_i),
    .threshold_i (threshold_i),
    .prescale_i  (prescale_i),
    .gpio_o      (gpio_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One clock: inputs change on negedges, outputs are read on negedges.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Step until gpio_o[pin]==val or the budget runs out; cyc is steps taken.
  task automatic wait_bit(input int pin, input logic val, input int max_cyc, output int cyc);
    cyc = 0;
    while (gpio_o[pin] !== val && cyc < max_cyc) begin
      step();
      cyc++;
    end
  endtask

  // ---------------- reference model ----------------
  // A pin accepts a new synchronized level on a tick once the number of
  // ticks seen since the disagreement began reaches max(threshold,1).
  pins_t m_hist[$];
  pins_t m_gpio, m_rise, m_fall;
  int    m_start[N];
  int    m_cyc;

  // Ticks fall on cycles c with c % (p+1) == p; count them within [a,b].
  function automatic int ticks_in(input int a, input int b, input int p);
    return (b + 1) / (p + 1) - a / (p + 1);
  endfunction

  task automatic model_reset();
    m_hist = {};
    for (int k = 0; k < Sync; k++) m_hist.push_back('0);
    m_gpio = '0;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < N; i++) m_start[i] = -1;
    m_cyc = 0;
  endtask

  task automatic model_step();
    pins_t s, prev;
    int    p, need;
    bit    tick_now;
    s = m_hist[$];
    m_hist.pop_back();
    m_hist.push_front(pad_i);
    p        = int'(prescale_i);
    need     = (threshold_i == '0) ? 1 : int'(threshold_i);
    tick_now = (m_cyc % (p + 1)) == p;
    prev     = m_gpio;
    for (int i = 0; i < N; i++) begin
      if (!filt_en_i[i]) begin
        m_gpio[i]  = s[i];
        m_start[i] = -1;
      end else if (s[i] == m_gpio[i]) begin
        m_start[i] = -1;
      end else begin
        if (m_start[i] < 0) m_start[i] = m_cyc;
        if (tick_now && ticks_in(m_start[i], m_cyc, p) >= need) begin
          m_gpio[i]  = s[i];
          m_start[i] = -1;
        end
      end
    end
    m_rise = m_gpio & ~prev;
    m_fall = ~m_gpio & prev;
    m_cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    model_reset();
  endtask

  function automatic row_t mk(input pins_t pad, input pins_t en, input pins_t g,
                              input pins_t r, input pins_t f);
    row_t v;
    v.pad = pad; v.en = en; v.gpio = g; v.rise = r; v.fall = f;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t  rows[13];
    int    cyc;
    pins_t quiet;
    logic  seen;

    // Bypass vectors: inputs applied before each edge, outputs checked after it.
    rows[0]  = mk(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    rows[1]  = mk(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    rows[2]  = mk(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00);
    rows[3]  = mk(8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00);
    rows[4]  = mk(8'h0F, 8'h00, 8'hFF, 8'h00, 8'h00);
    rows[5]  = mk(8'h0F, 8'h00, 8'hFF, 8'h00, 8'h00);
    rows[6]  = mk(8'h0F, 8'h00, 8'h0F, 8'h00, 8'hF0);
    rows[7]  = mk(8'h0F, 8'h00, 8'h0F, 8'h00, 8'h00);
    rows[8]  = mk(8'h8F, 8'h00, 8'h0F, 8'h00, 8'h00);
    rows[9]  = mk(8'h0F, 8'h00, 8'h0F, 8'h00, 8'h00);
    rows[10] = mk(8'h0F, 8'h00, 8'h8F, 8'h80, 8'h00);
    rows[11] = mk(8'h0F, 8'h00, 8'h0F, 8'h00, 8'h80);
    rows[12] = mk(8'h0F, 8'h00, 8'h0F, 8'h00, 8'h00);

    // Reset with all pads high: outputs held at zero.
    rst_ni      = 1'b0;
    pad_i       = '1;
    filt_en_i   = '0;
    threshold_i = cnt_t'(4);
    prescale_i  = '0;
    step();
    step();
    check("reset gpio_o", 32'(gpio_o), 0);
    check("reset rise_o", 32'(rise_o), 0);
    check("reset fall_o", 32'(fall_o), 0);
    rst_ni = 1'b1;

    for (int r = 0; r < 13; r++) begin
      pad_i     = rows[r].pad;
      filt_en_i = rows[r].en;
      step();
      check($sformatf("vec%0d gpio_o", r), 32'(gpio_o), 32'(rows[r].gpio));
      check($sformatf("vec%0d rise_o", r), 32'(rise_o), 32'(rows[r].rise));
      check($sformatf("vec%0d fall_o", r), 32'(fall_o), 32'(rows[r].fall));
    end

    // Filter, prescale 0, threshold 4: short pulse rejected, held level accepted.
    pad_i = '0; filt_en_i = pins_t'(1); threshold_i = cnt_t'(4); prescale_i = '0;
    do_reset();
    step(); step(); step();
    pad_i[0] = 1'b1;
    step(); step(); step();
    pad_i[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      seen = seen | gpio_o[0] | rise_o[0];
    end
    check("3-cycle pulse rejected", 32'(seen), 0);
    pad_i[0] = 1'b1;
    wait_bit(0, 1'b1, 20, cyc);
    check("thr4 rise latency", cyc, Sync + 4);
    check("thr4 rise pulse", 32'(rise_o[0]), 1);
    step();
    check("thr4 rise pulse width", 32'(rise_o[0]), 0);
    check("thr4 level held", 32'(gpio_o[0]), 1);

    // Prescale 9, threshold 3: latency window across prescaler phases.
    pad_i = '0; filt_en_i = pins_t'(1); threshold_i = cnt_t'(3); prescale_i = pre_t'(9);
    do_reset();
    for (int t = 0; t < 3; t++) begin
      repeat (t * 4 + 1) step();
      pad_i[0] = ~pad_i[0];
      wait_bit(0, pad_i[0], 60, cyc);
      check_range($sformatf("prescaled latency %0d", t), cyc - Sync, 21, 30);
    end

    // One-cycle glitch after two ticks restarts the count: accept at edge 50, not 30.
    pad_i = pins_t'(1); filt_en_i = pins_t'(1); threshold_i = cnt_t'(3); prescale_i = pre_t'(9);
    do_reset();
    repeat (22) step();
    pad_i[0] = 1'b0;
    step();
    pad_i[0] = 1'b1;
    wait_bit(0, 1'b1, 60, cyc);
    check("glitch restarts count", 23 + cyc, 50);

    // Threshold 0 acts as 1.
    pad_i = pins_t'(1); filt_en_i = pins_t'(1); threshold_i = '0; prescale_i = '0;
    do_reset();
    wait_bit(0, 1'b1, 20, cyc);
    check("thr0 latency", cyc, Sync + 1);

    // Threshold lowered from 200 to 5 with the count at 50.
    pad_i = pins_t'(1); filt_en_i = pins_t'(1); threshold_i = cnt_t'(200); prescale_i = '0;
    do_reset();
    repeat (52) step();
    check("thr200 still counting", 32'(gpio_o[0]), 0);
    threshold_i = cnt_t'(5);
    step();
    check("thr lowered accepts", 32'(gpio_o[0]), 1);
    check("thr lowered rise", 32'(rise_o[0]), 1);

    // Filter disabled mid-count on pin 3.
    pad_i = pins_t'(8); filt_en_i = pins_t'(8); threshold_i = cnt_t'(200); prescale_i = '0;
    do_reset();
    repeat (10) step();
    check("pin3 counting", 32'(gpio_o[3]), 0);
    filt_en_i = '0;
    step();
    check("pin3 bypass gpio_o", 32'(gpio_o), 32'h08);
    check("pin3 bypass rise", 32'(rise_o[3]), 1);
    step();
    check("pin3 bypass rise width", 32'(rise_o[3]), 0);

    // Asynchronous reset mid-count on all pins.
    pad_i = '1; filt_en_i = '1; threshold_i = cnt_t'(10); prescale_i = '0;
    do_reset();
    wait_bit(0, 1'b1, 40, cyc);
    check("all-pin rise latency", cyc, Sync + 10);
    check("all-pin gpio_o high", 32'(gpio_o), 32'(8'hFF));
    pad_i = '0;
    repeat (5) step();
    check("all-pin fall pending", 32'(gpio_o), 32'(8'hFF));
    #2 rst_ni = 1'b0;
    #1;
    check("async reset gpio_o", 32'(gpio_o), 0);
    check("async reset rise_o", 32'(rise_o), 0);
    check("async reset fall_o", 32'(fall_o), 0);
    step();
    step();
    rst_ni = 1'b1;
    quiet = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      quiet = quiet | gpio_o | rise_o | fall_o;
    end
    check("quiet after reset", 32'(quiet), 0);
    pad_i = '1;
    wait_bit(0, 1'b1, 40, cyc);
    check("post-reset rise latency", cyc, Sync + 10);
    check("post-reset rise_o", 32'(rise_o), 32'(8'hFF));

    // Randomized run against the reference model.
    for (int seg = 0; seg < 4; seg++) begin
      pad_i       = '0;
      filt_en_i   = pins_t'($urandom);
      threshold_i = cnt_t'($urandom_range(0, 5));
      prescale_i  = pre_t'($urandom_range(0, 3));
      do_reset();
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 11) == 0) pad_i[i] = ~pad_i[i];
        if ($urandom_range(0, 63) == 0) filt_en_i = pins_t'($urandom);
        if ($urandom_range(0, 63) == 0) threshold_i = cnt_t'($urandom_range(0, 5));
        model_step();
        step();
        check($sformatf("rand s%0d c%0d gpio_o", seg, c), 32'(gpio_o), 32'(m_gpio));
        check($sformatf("rand s%0d c%0d rise_o", seg, c), 32'(rise_o), 32'(m_rise));
        check($sformatf("rand s%0d c%0d fall_o", seg, c), 32'(fall_o), 32'(m_fall));
        check($sformatf("rand s%0d c%0d rise&fall", seg, c), 32'(rise_o & fall_o), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
